uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter NUM_REQ, default 4, SHALL set the number of requesters (2..8).
REQ-003 Parameter WDOG_CYCLES, default 64, SHALL set the watchdog limit in clk cycles.
REQ-004 clk  in  1  system clock; all flops on rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 req  in  NUM_REQ  per-requester byte-pending request.
REQ-007 req_data  in  NUM_REQ*8  byte for requester i in bits [8i+7:8i].
REQ-008 gnt  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i accepted.
REQ-009 tx_start  out  1  one-cycle start pulse to the UART transmitter.
REQ-010 tx_data  out  8  registered byte to the UART transmitter.
REQ-011 tx_busy  in  1  UART transmitter busy flag.
REQ-012 arb_busy  out  1  high in every state except IDLE.
REQ-013 arb_owner  out  $clog2(NUM_REQ)  index of last granted requester.
REQ-014 err_timeout  out  1  sticky watchdog error flag.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-016 In IDLE with any req bit high, the block SHALL choose a winner round-robin, starting the search at arb_owner+1 and wrapping modulo NUM_REQ, then go to ISSUE on the next edge.
REQ-017 On that edge the block SHALL latch req_data of the winner into tx_data, update arb_owner to the winner and register gnt one-hot for the winner.
REQ-018 tx_start and gnt SHALL be high for exactly the single ISSUE cycle; ISSUE SHALL then go unconditionally to WAIT_BUSY.
REQ-019 WAIT_BUSY SHALL go to WAIT_DONE on the first cycle tx_busy=1.
REQ-020 WAIT_DONE SHALL go to IDLE on the first cycle tx_busy=0.
REQ-021 The block SHALL sample req only in IDLE; req changes in other states SHALL have no effect.
REQ-022 A requester SHALL hold req and req_data stable until its gnt pulse; after gnt, req low means no further byte.
REQ-023 Latency from req rising in IDLE to tx_start SHALL be exactly 1 cycle.
REQ-024 Back-to-back bytes SHALL be separated by exactly one IDLE cycle after tx_busy falls.
REQ-025 With all req low, the FSM SHALL stay in IDLE with tx_start=0 and gnt=0.
REQ-026 tx_data SHALL hold its value outside ISSUE entry.

Reset
REQ-027 While reset_n=0, all flops SHALL clear asynchronously: state=IDLE, tx_start=0, tx_data=0, gnt=0, err_timeout=0, arb_owner=NUM_REQ-1, so requester 0 wins first.
REQ-028 Reset asserted mid-transfer SHALL abandon the byte with no gnt replay; the UART transmitter is reset by the same system reset.

Configuration
REQ-029 With macro UART_ARB_WDOG_EN defined, a counter SHALL run in WAIT_BUSY; if tx_busy stays 0 for WDOG_CYCLES cycles, the FSM SHALL return to IDLE and set err_timeout, which stays set until reset.
REQ-030 Without UART_ARB_WDOG_EN, WAIT_BUSY SHALL wait indefinitely, err_timeout SHALL be tied 0, and no counter SHALL be synthesised.

Structure
REQ-031 Package uart_pkg SHALL hold the arbiter state enum (2-bit) and the constant UART_DATA_W=8.
REQ-032 The round-robin search SHALL be sub-module rr_pick: combinational, with inputs req and last-owner pointer and outputs winner index and valid.

Verification
REQ-033 After reset, req=4'b0001, req_data[7:0]=8'hA5: gnt=4'b0001 and tx_start=1 on the same single cycle, tx_data=8'hA5, arb_owner=0.
REQ-034 req=4'b1111 held, with each requester dropping req after its gnt: grant order is 0,1,2,3 and exactly one tx_start per byte.
REQ-035 arb_owner=2 and req=4'b0101: requester 0 wins (wrap), then requester 2.
REQ-036 Model tx_busy high for 10 cycles starting 1 cycle after tx_start: the next tx_start comes exactly 2 cycles after tx_busy falls.
REQ-037 UART_ARB_WDOG_EN defined, WDOG_CYCLES=8, tx_busy held 0: err_timeout rises 8 cycles after WAIT_BUSY entry, FSM returns to IDLE and the flag stays set.
REQ-038 Drive reset_n low during WAIT_DONE: all outputs clear immediately, and the first grant after release goes to requester 0.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//
// Shared definitions for the UART transmit arbiter:
//   UART_DATA_W  - width of one UART byte
//   arb_state_t  - 2-bit arbiter FSM state encoding
//
// Imported by uart_tx_arbiter and rr_pick.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//
// Combinational round-robin winner search. The search starts one position
// after the last owner and wraps modulo NUM_REQ, so the last owner has the
// lowest priority on the next pick.
//
// Ports:
//   req    in   NUM_REQ  pending requests
//   last   in   IDX_W    index of the previous winner
//   winner out  IDX_W    index of the chosen requester (0 when none)
//   valid  out  1        at least one request is pending
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    // Candidate gi is the requester (last + 1 + gi) mod NUM_REQ; candidate 0
    // has the highest priority.
    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_req;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [IDX_W:0] sum;

        // One extra bit holds last + offset without overflow (max 2*NUM_REQ-1).
        assign sum = {1'b0, last} + (IDX_W + 1)'(gi + 1);

        assign cand_idx[gi] = (sum >= (IDX_W + 1)'(NUM_REQ))
                            ? IDX_W'(sum - (IDX_W + 1)'(NUM_REQ))
                            : IDX_W'(sum);

        assign cand_req[gi] = req[cand_idx[gi]];
    end

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand_req[i]) begin
                winner = cand_idx[i];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter that lets NUM_REQ requesters share one UART
// transmitter. Each accepted byte produces a one-cycle gnt pulse to its
// owner together with a one-cycle tx_start to the transmitter, then the
// arbiter waits for the transmitter to go busy and idle again before
// picking the next byte.
//
// Parameters:
//   NUM_REQ      number of requesters (2..8)
//   WDOG_CYCLES  watchdog limit in clk cycles for the WAIT_BUSY state
//
// Ports:
//   clk          in   1              system clock, rising edge
//   reset_n      in   1              asynchronous active-low reset
//   req          in   NUM_REQ        per-requester byte pending
//   req_data     in   NUM_REQ*8      byte of requester i in [8i+7:8i]
//   gnt          out  NUM_REQ        one-hot pulse: byte of requester i taken
//   tx_start     out  1              one-cycle start pulse to the transmitter
//   tx_data      out  8              byte presented to the transmitter
//   tx_busy      in   1              transmitter busy flag
//   arb_busy     out  1              high in every state except IDLE
//   arb_owner    out  clog2(NUM_REQ) index of last granted requester
//   err_timeout  out  1              sticky watchdog error
//
// Build option:
//   UART_ARB_WDOG_EN  when defined, a watchdog aborts WAIT_BUSY if tx_busy
//                     never rises within WDOG_CYCLES cycles and sets the
//                     sticky err_timeout flag. When undefined, WAIT_BUSY
//                     waits indefinitely and err_timeout is constant 0.
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]             gnt,
    output logic                           tx_start,
    output logic [UART_DATA_W-1:0]         tx_data,
    input  logic                           tx_busy,
    output logic                           arb_busy,
    output logic [$clog2(NUM_REQ)-1:0]     arb_owner,
    output logic                           err_timeout
);

    localparam int OWNER_W = $clog2(NUM_REQ);

    // Elaboration-time parameter sanity check.
    if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 1) begin : g_bad_param
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and WDOG_CYCLES >= 1");
    end

    // -------------------------------------------------------------------------
    // Per-requester byte view of the flat data bus
    // -------------------------------------------------------------------------
    logic [UART_DATA_W-1:0] req_byte [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
        assign req_byte[gi] = req_data[gi*UART_DATA_W +: UART_DATA_W];
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    arb_state_t              state_reg;
    logic                    tx_start_reg;
    logic [UART_DATA_W-1:0]  tx_data_reg;
    logic [NUM_REQ-1:0]      gnt_reg;
    logic [OWNER_W-1:0]      owner_reg;

    // -------------------------------------------------------------------------
    // Round-robin search, only acted on while in IDLE
    // -------------------------------------------------------------------------
    logic [OWNER_W-1:0] pick_idx;
    logic               pick_valid;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OWNER_W)
    ) u_rr_pick (
        .req    (req),
        .last   (owner_reg),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    // -------------------------------------------------------------------------
    // Optional watchdog on WAIT_BUSY
    // -------------------------------------------------------------------------
`ifdef UART_ARB_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt_reg;
    logic              err_reg;
    logic              wdog_expired;

    // Expires on the WDOG_CYCLES-th consecutive WAIT_BUSY cycle with no busy.
    assign wdog_expired = (state_reg == ST_WAIT_BUSY) && !tx_busy &&
                          (wdog_cnt_reg == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            if (state_reg == ST_WAIT_BUSY && !tx_busy && !wdog_expired) begin
                wdog_cnt_reg <= wdog_cnt_reg + WDOG_W'(1);
            end else begin
                wdog_cnt_reg <= '0;
            end
            // Sticky until the next reset.
            if (wdog_expired) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err_timeout = err_reg;
`else
    assign err_timeout = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Arbiter FSM. Outputs are registered; gnt and tx_start default low so
    // they are single-cycle pulses during ISSUE.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= '0;
            gnt_reg      <= '0;
            // Pointing at the last requester makes requester 0 win first.
            owner_reg    <= OWNER_W'(NUM_REQ - 1);
        end else begin
            tx_start_reg <= 1'b0;
            gnt_reg      <= '0;

            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_reg    <= ST_ISSUE;
                        tx_start_reg <= 1'b1;
                        gnt_reg      <= NUM_REQ'(1) << pick_idx;
                        tx_data_reg  <= req_byte[pick_idx];
                        owner_reg    <= pick_idx;
                    end
                end

                ST_ISSUE: begin
                    state_reg <= ST_WAIT_BUSY;
                end

                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_reg <= ST_WAIT_DONE;
                    end
`ifdef UART_ARB_WDOG_EN
                    else if (wdog_expired) begin
                        state_reg <= ST_IDLE;
                    end
`endif
                end

                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_reg;
    assign tx_start  = tx_start_reg;
    assign tx_data   = tx_data_reg;
    assign arb_owner = owner_reg;
    assign arb_busy  = (state_reg != ST_IDLE);

endmodule
